// File: rtl/matmul_pkg.sv
// Shared types and default sizes for the systolic-array feed path.
package matmul_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_MEM_DEPTH  = 9;
    localparam int DEF_BLOCK_SIZE = 4;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        RD_ISSUE = 3'd2,
        RD_WAIT  = 3'd3,
        OUT_HOLD = 3'd4
    } ctrl_state_t;

endpackage

// File: rtl/data_mem_ctrl.sv
// Initiator for Data_Mem: streams bytes in on a handshake, then returns the
// contents as strided blocks on a handshake toward the array-feed logic.
module data_mem_ctrl
    import matmul_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MEM_DEPTH  = DEF_MEM_DEPTH,
    parameter int BLOCK_SIZE = DEF_BLOCK_SIZE,
    localparam int ADDR_W    = $clog2(MEM_DEPTH),
    localparam int PTR_W     = $clog2(MEM_DEPTH + BLOCK_SIZE)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             load_start,
    input  logic                             read_start,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [DATA_WIDTH-1:0]            in_data,
    output logic                             load_done,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [BLOCK_SIZE*DATA_WIDTH-1:0] out_data,
    output logic                             out_last,
    output logic                             busy,
    output logic                             mem_wr_en,
    output logic                             mem_rd_en,
    output logic [ADDR_W-1:0]                mem_addr,
    output logic [DATA_WIDTH-1:0]            mem_data_in,
    input  logic [BLOCK_SIZE*DATA_WIDTH-1:0] mem_data_out
);

    localparam logic [PTR_W-1:0] PTR_DEPTH = PTR_W'(MEM_DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(MEM_DEPTH - 1);
    localparam logic [PTR_W-1:0] PTR_STEP  = PTR_W'(BLOCK_SIZE);
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

    ctrl_state_t      state;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_next;
    logic             in_fire;

    // PTR_W leaves headroom so the stride past the final block cannot wrap.
    assign rd_next = rd_ptr + PTR_STEP;
    assign in_fire = in_valid && in_ready;

    // NOTE: every register here is state, so all updates are non-blocking; the
    // block reads a consistent pre-edge snapshot no matter the statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            in_ready    <= 1'b0;
            load_done   <= 1'b0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_last    <= 1'b0;
            busy        <= 1'b0;
            mem_wr_en   <= 1'b0;
            mem_rd_en   <= 1'b0;
            mem_addr    <= '0;
            mem_data_in <= '0;
        end else begin
            load_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load_start) begin
                        state    <= LOAD;
                        busy     <= 1'b1;
                        wr_ptr   <= '0;
                        in_ready <= 1'b1;
                    end else if (read_start) begin
                        state     <= RD_ISSUE;
                        busy      <= 1'b1;
                        rd_ptr    <= '0;
                        mem_rd_en <= 1'b1;
                        mem_addr  <= '0;
                    end
                end

                LOAD: begin
                    if (in_fire) begin
                        mem_wr_en   <= 1'b1;
                        mem_addr    <= ADDR_W'(wr_ptr);
                        mem_data_in <= in_data;
                        wr_ptr      <= wr_ptr + PTR_ONE;
                        if (wr_ptr == PTR_LAST) begin
                            in_ready <= 1'b0;
                        end
                    end else begin
                        mem_wr_en <= 1'b0;
                        // Full pointer with in_ready low: the last write is landing now.
                        if (wr_ptr == PTR_DEPTH) begin
                            load_done <= 1'b1;
                            busy      <= 1'b0;
                            state     <= IDLE;
                        end
                    end
                end

                RD_ISSUE: begin
                    mem_rd_en <= 1'b0;
                    state     <= RD_WAIT;
                end

                RD_WAIT: begin
                    out_data  <= mem_data_out;
                    out_last  <= (rd_next >= PTR_DEPTH);
                    out_valid <= 1'b1;
                    state     <= OUT_HOLD;
                end

                OUT_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (out_last) begin
                            out_last <= 1'b0;
                            busy     <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            rd_ptr    <= rd_next;
                            mem_rd_en <= 1'b1;
                            mem_addr  <= ADDR_W'(rd_next);
                            state     <= RD_ISSUE;
                        end
                    end
                end

                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
